reload_param_loader: RTL and testbench
======================================

Name: reload_param_loader

Overview:
Parametrised successor to the dump-reload parameter capture. The CPU streams a header, dump offset, PRG length and CHR length as bytes through one I/O data register. The block holds them in shadow registers and checks an optional trailing 8-bit checksum. It commits all fields atomically to the cartridge loader, with a one-cycle load_dump pulse. It adds an abort/clear control register, an inter-byte watchdog and status readback.

Parameters:
DATA_ADDR, 5'h18, I/O register address for the parameter byte stream
CTRL_ADDR, 5'h19, I/O register address for control writes and status reads
MAPPER_W, 4, mapper_type width (1..7); header bit MAPPER_W is solder_mirror
PRG_LEN_DEFAULT, 16'd64, dump_prg_len reset/reload value (units of 512 B)
CHR_LEN_DEFAULT, 16'd16, dump_chr_len reset/reload value (units of 512 B)
CHECKSUM_EN, 1, 1: stream is 10 bytes with trailing checksum; 0: stream is 9 bytes, no check
TIMEOUT_W, 16, watchdog width in cpu_clock enables

Ports:
sysclk  in  1  system clock, only clock
reset  in  1  asynchronous active-low reset
cpu_clock  in  1  CPU bus enable, one sysclk wide
rld_cs  in  1  reload register block select
ioreg_addr  in  5  I/O register address
ioreg_datain  in  8  write data
ioreg_wr  in  1  1 = write, 0 = read
reload  in  1  forces defaults and a load_dump pulse
ioreg_dataout  out  8  status byte
ioreg_oe  out  1  status read active
load_dump  out  1  one-cycle load request
mapper_type  out  MAPPER_W  committed mapper
solder_mirror  out  1  committed mirroring
dump_offset  out  32  committed dump byte offset
dump_prg_len  out  16  committed PRG length
dump_chr_len  out  16  committed CHR length
load_error  out  1  either error flag is set

Behaviour:
- Data strobe: wr_d = cpu_clock & rld_cs & ioreg_wr & (ioreg_addr==DATA_ADDR). Control strobe wr_c is the same with CTRL_ADDR.
- Reset (async, low): state IDLE; byte_cnt 0; sum 0; shadows 0; live mapper/mirror/offset 0; prg/chr lengths set to their defaults; load_dump 0; both error flags 0; watchdog 0.
- Stream order: byte 0 is the header, bytes 1-4 are offset LSB-first, bytes 5-6 are PRG length LSB-first, bytes 7-8 are CHR length LSB-first, and byte 9 is the checksum when enabled.
- The checksum is valid when the mod-256 sum of all 10 bytes equals 0.
- States are IDLE, COLLECT and CHECK.
- IDLE: on wr_d, store byte 0 and set sum to that byte. Set byte_cnt to 1, go to COLLECT, and clear the watchdog.
- COLLECT: each wr_d stores byte[byte_cnt] to its shadow, adds it to sum, increments byte_cnt and clears the watchdog. On the last byte (index 9, or 8 when CHECKSUM_EN=0), go to CHECK.
- CHECK lasts exactly one sysclk cycle, and wr_d in CHECK is ignored.
  - If the sum is valid (or checking is disabled), copy shadows to live outputs at the next edge, set load_dump=1 for one cycle and clear err_cksum.
  - Otherwise, live outputs are unchanged, err_cksum=1 and there is no pulse.
  - Either way, go to IDLE with byte_cnt 0.
- Latency: last-byte write edge E0; outputs and load_dump change at E0+2 sysclk edges; load_dump falls at E0+3.
- Watchdog: increments on cpu_clock while in COLLECT. At all-ones it sets err_timeout, returns to IDLE and discards the shadows (live outputs unchanged).
- wr_c writes:
  - bit0 abort: go to IDLE, byte_cnt 0, no commit.
  - bit1: clear both error flags.
  - Both bits may be set together.
- reload has highest priority over wr_d, wr_c and the watchdog. Next edge:
  - state IDLE, byte_cnt 0, shadows cleared;
  - live mapper/mirror/offset 0, lengths to their defaults;
  - load_dump=1; error flags unchanged.
- Status read: ioreg_oe = rld_cs & ~ioreg_wr & (ioreg_addr==CTRL_ADDR), combinational. ioreg_dataout = {busy (state!=IDLE), err_cksum, err_timeout, 1'b0, byte_cnt[3:0]}. When ioreg_oe=0, ioreg_dataout is 0.
- Header bits above MAPPER_W are ignored.
- A reset mid-stream loses the partial stream; outputs return to reset values.

Decomposition:
- Package reload_pkg holds:
  - the state enum (IDLE, COLLECT, CHECK);
  - stream byte index constants (HDR=0, OFS0..3=1..4, PRG0/1=5/6, CHR0/1=7/8, CKS=9);
  - status bit positions;
  - control bit positions (ABORT=0, CLRERR=1).
- One sub-module, reload_watchdog: a TIMEOUT_W counter with clear, count-enable and expire outputs.

Test Plan:
- Stream 0x13,0x00,0x02,0x00,0x00,0x80,0x00,0x20,0x00,cks=0x4B -> at E0+2: mapper 3, mirror 1, offset 0x200, prg 0x80, chr 0x20; load_dump high 1 cycle; load_error 0.
- Same stream with cks=0x4C -> no pulse; outputs stay at 0/0/0/64/16; status reads 0x40; wr_c 0x02 -> status 0x00.
- 4 bytes then no writes (TIMEOUT_W=4) -> after 15 cpu_clock enables status=0x20, busy 0; a fresh full valid stream then commits.
- 5 bytes then wr_c 0x01 -> status 0x00, outputs unchanged; the next stream starts at byte 0.
- reload asserted in the same cycle as the final wr_d -> outputs go to defaults (prg 64, chr 16), one load_dump pulse, no commit of the stream.
- CHECKSUM_EN=0, 9-byte stream -> commit with pulse at E0+2; a 10th write starts a new stream (status byte_cnt=1).

Source files
------------

// File: rtl/reload_pkg.sv
// Shared types and constants for the reload parameter loader.
package reload_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam logic [3:0] IDX_HDR  = 4'd0;
    localparam logic [3:0] IDX_OFS0 = 4'd1;
    localparam logic [3:0] IDX_OFS1 = 4'd2;
    localparam logic [3:0] IDX_OFS2 = 4'd3;
    localparam logic [3:0] IDX_OFS3 = 4'd4;
    localparam logic [3:0] IDX_PRG0 = 4'd5;
    localparam logic [3:0] IDX_PRG1 = 4'd6;
    localparam logic [3:0] IDX_CHR0 = 4'd7;
    localparam logic [3:0] IDX_CHR1 = 4'd8;
    localparam logic [3:0] IDX_CKS  = 4'd9;

    localparam int STAT_BUSY        = 7;
    localparam int STAT_ERR_CKSUM   = 6;
    localparam int STAT_ERR_TIMEOUT = 5;

    localparam int CTRL_ABORT  = 0;
    localparam int CTRL_CLRERR = 1;

    function automatic logic [7:0] pack_status(input logic busy, input logic err_cksum,
                                               input logic err_timeout, input logic [3:0] cnt);
        logic [7:0] s;
        s = {4'b0000, cnt};
        s[STAT_BUSY]        = busy;
        s[STAT_ERR_CKSUM]   = err_cksum;
        s[STAT_ERR_TIMEOUT] = err_timeout;
        return s;
    endfunction

endpackage

// File: rtl/reload_watchdog.sv
// Inter-byte watchdog: counts enables, saturates at all-ones and flags expiry there.
module reload_watchdog #(
    parameter int TIMEOUT_W = 16
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [TIMEOUT_W-1:0] count;

    assign expired = &count;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

endmodule

// File: rtl/reload_param_loader.sv
// Captures a streamed parameter block, validates it and commits it atomically.
// States: IDLE waits for the header | COLLECT gathers bytes | CHECK validates for one cycle.
module reload_param_loader
    import reload_pkg::*;
#(
    parameter logic [4:0]  DATA_ADDR       = 5'h18,
    parameter logic [4:0]  CTRL_ADDR       = 5'h19,
    parameter int          MAPPER_W        = 4,
    parameter logic [15:0] PRG_LEN_DEFAULT = 16'd64,
    parameter logic [15:0] CHR_LEN_DEFAULT = 16'd16,
    parameter bit          CHECKSUM_EN     = 1'b1,
    parameter int          TIMEOUT_W       = 16
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                cpu_clock,
    input  logic                rld_cs,
    input  logic [4:0]          ioreg_addr,
    input  logic [7:0]          ioreg_datain,
    input  logic                ioreg_wr,
    input  logic                reload,
    output logic [7:0]          ioreg_dataout,
    output logic                ioreg_oe,
    output logic                load_dump,
    output logic [MAPPER_W-1:0] mapper_type,
    output logic                solder_mirror,
    output logic [31:0]         dump_offset,
    output logic [15:0]         dump_prg_len,
    output logic [15:0]         dump_chr_len,
    output logic                load_error
);

    localparam logic [3:0] LAST_IDX = CHECKSUM_EN ? IDX_CKS : IDX_CHR1;

    state_t        state;
    logic [3:0]    byte_cnt;
    logic [7:0]    sum;
    logic [MAPPER_W:0] shadow_hdr;
    logic [31:0]   shadow_ofs;
    logic [15:0]   shadow_prg;
    logic [15:0]   shadow_chr;
    logic          commit_req;
    logic          err_cksum;
    logic          err_timeout;
    logic          wd_expired;

    logic wr_d, wr_c, abort, sum_ok;

    assign wr_d   = cpu_clock & rld_cs & ioreg_wr & (ioreg_addr == DATA_ADDR);
    assign wr_c   = cpu_clock & rld_cs & ioreg_wr & (ioreg_addr == CTRL_ADDR);
    assign abort  = wr_c & ioreg_datain[CTRL_ABORT];
    assign sum_ok = !CHECKSUM_EN || (sum == 8'd0);

    reload_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
        .sysclk   (sysclk),
        .reset    (reset),
        .clear    ((state != COLLECT) | wr_d | reload | abort),
        .count_en (cpu_clock & (state == COLLECT)),
        .expired  (wd_expired)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            byte_cnt      <= 4'd0;
            sum           <= 8'd0;
            shadow_hdr    <= '0;
            shadow_ofs    <= 32'd0;
            shadow_prg    <= 16'd0;
            shadow_chr    <= 16'd0;
            commit_req    <= 1'b0;
            mapper_type   <= '0;
            solder_mirror <= 1'b0;
            dump_offset   <= 32'd0;
            dump_prg_len  <= PRG_LEN_DEFAULT;
            dump_chr_len  <= CHR_LEN_DEFAULT;
            load_dump     <= 1'b0;
            err_cksum     <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            load_dump  <= 1'b0;
            commit_req <= 1'b0;
            if (reload) begin
                state         <= IDLE;
                byte_cnt      <= 4'd0;
                sum           <= 8'd0;
                shadow_hdr    <= '0;
                shadow_ofs    <= 32'd0;
                shadow_prg    <= 16'd0;
                shadow_chr    <= 16'd0;
                mapper_type   <= '0;
                solder_mirror <= 1'b0;
                dump_offset   <= 32'd0;
                dump_prg_len  <= PRG_LEN_DEFAULT;
                dump_chr_len  <= CHR_LEN_DEFAULT;
                load_dump     <= 1'b1;
            end else begin
                // Commit lands one edge after CHECK so the pulse and outputs move together.
                if (commit_req) begin
                    mapper_type   <= shadow_hdr[MAPPER_W-1:0];
                    solder_mirror <= shadow_hdr[MAPPER_W];
                    dump_offset   <= shadow_ofs;
                    dump_prg_len  <= shadow_prg;
                    dump_chr_len  <= shadow_chr;
                    load_dump     <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (wr_d) begin
                            shadow_hdr <= ioreg_datain[MAPPER_W:0];
                            sum        <= ioreg_datain;
                            byte_cnt   <= 4'd1;
                            state      <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (wd_expired) begin
                            state       <= IDLE;
                            byte_cnt    <= 4'd0;
                            sum         <= 8'd0;
                            shadow_hdr  <= '0;
                            shadow_ofs  <= 32'd0;
                            shadow_prg  <= 16'd0;
                            shadow_chr  <= 16'd0;
                            err_timeout <= 1'b1;
                        end else if (wr_d) begin
                            case (byte_cnt)
                                IDX_OFS0: shadow_ofs[7:0]   <= ioreg_datain;
                                IDX_OFS1: shadow_ofs[15:8]  <= ioreg_datain;
                                IDX_OFS2: shadow_ofs[23:16] <= ioreg_datain;
                                IDX_OFS3: shadow_ofs[31:24] <= ioreg_datain;
                                IDX_PRG0: shadow_prg[7:0]   <= ioreg_datain;
                                IDX_PRG1: shadow_prg[15:8]  <= ioreg_datain;
                                IDX_CHR0: shadow_chr[7:0]   <= ioreg_datain;
                                IDX_CHR1: shadow_chr[15:8]  <= ioreg_datain;
                                default: ;
                            endcase
                            sum      <= sum + ioreg_datain;
                            byte_cnt <= byte_cnt + 4'd1;
                            if (byte_cnt == LAST_IDX) begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        state    <= IDLE;
                        byte_cnt <= 4'd0;
                        if (sum_ok) begin
                            commit_req <= 1'b1;
                            err_cksum  <= 1'b0;
                        end else begin
                            err_cksum  <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        byte_cnt <= 4'd0;
                    end
                endcase
                if (abort) begin
                    state      <= IDLE;
                    byte_cnt   <= 4'd0;
                    commit_req <= 1'b0;
                end
                if (wr_c && ioreg_datain[CTRL_CLRERR]) begin
                    err_cksum   <= 1'b0;
                    err_timeout <= 1'b0;
                end
            end
        end
    end

    assign ioreg_oe      = rld_cs & ~ioreg_wr & (ioreg_addr == CTRL_ADDR);
    assign ioreg_dataout = ioreg_oe ? pack_status(state != IDLE, err_cksum, err_timeout, byte_cnt)
                                    : 8'h00;
    assign load_error    = err_cksum | err_timeout;

endmodule

// File: tb/tb_reload_param_loader.sv
// Directed bench: a checksummed instance (a) and a no-checksum instance (b), both with a 4-bit watchdog.
module tb_reload_param_loader;

    localparam logic [4:0] DATA = 5'h18;
    localparam logic [4:0] CTRL = 5'h19;

    logic sysclk = 1'b0, reset = 1'b0, cpu_clock = 1'b0, ioreg_wr = 1'b0, reload = 1'b0;
    logic cs_a = 1'b0, cs_b = 1'b0;
    logic [4:0] addr = 5'h00;
    logic [7:0] din = 8'h00;

    logic [7:0]  dout_a, dout_b;
    logic        oe_a, oe_b, ld_a, ld_b, mir_a, mir_b, err_a, err_b;
    logic [3:0]  map_a, map_b;
    logic [31:0] ofs_a, ofs_b;
    logic [15:0] prg_a, prg_b, chr_a, chr_b;

    int total = 0;
    int bad = 0;

    reload_param_loader #(.CHECKSUM_EN(1'b1), .TIMEOUT_W(4)) dut_a (
        .sysclk(sysclk), .reset(reset), .cpu_clock(cpu_clock), .rld_cs(cs_a),
        .ioreg_addr(addr), .ioreg_datain(din), .ioreg_wr(ioreg_wr), .reload(reload),
        .ioreg_dataout(dout_a), .ioreg_oe(oe_a), .load_dump(ld_a), .mapper_type(map_a),
        .solder_mirror(mir_a), .dump_offset(ofs_a), .dump_prg_len(prg_a),
        .dump_chr_len(chr_a), .load_error(err_a)
    );

    reload_param_loader #(.CHECKSUM_EN(1'b0), .TIMEOUT_W(4)) dut_b (
        .sysclk(sysclk), .reset(reset), .cpu_clock(cpu_clock), .rld_cs(cs_b),
        .ioreg_addr(addr), .ioreg_datain(din), .ioreg_wr(ioreg_wr), .reload(reload),
        .ioreg_dataout(dout_b), .ioreg_oe(oe_b), .load_dump(ld_b), .mapper_type(map_b),
        .solder_mirror(mir_b), .dump_offset(ofs_b), .dump_prg_len(prg_b),
        .dump_chr_len(chr_b), .load_error(err_b)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [79:0] bytes;
        logic        commit;
        logic [3:0]  mapper;
        logic        mirror;
        logic [31:0] ofs;
        logic [15:0] prg;
        logic [15:0] chr;
        logic [7:0]  status;
        bit          clr;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [79:0] mk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8, b9);
        return {b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input bit sel_b, input logic [4:0] a, input logic [7:0] d, input bit rl);
        @(negedge sysclk);
        cpu_clock = 1'b1; cs_a = !sel_b; cs_b = sel_b; ioreg_wr = 1'b1; addr = a; din = d; reload = rl;
        @(posedge sysclk);
        #1;
        cpu_clock = 1'b0; cs_a = 1'b0; cs_b = 1'b0; ioreg_wr = 1'b0; reload = 1'b0;
    endtask

    task automatic idle_pulse();
        @(negedge sysclk);
        cpu_clock = 1'b1;
        @(posedge sysclk);
        #1;
        cpu_clock = 1'b0;
    endtask

    task automatic read_status(input bit sel_b, output logic [7:0] v, output logic oe);
        @(negedge sysclk);
        cs_a = !sel_b; cs_b = sel_b; ioreg_wr = 1'b0; addr = CTRL;
        #1;
        v  = sel_b ? dout_b : dout_a;
        oe = sel_b ? oe_b : oe_a;
        cs_a = 1'b0; cs_b = 1'b0;
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check_status(input string name, input bit sel_b, input logic [7:0] exp);
        logic [7:0] v;
        logic oe;
        read_status(sel_b, v, oe);
        check({name, "_oe"}, oe, 1'b1);
        check(name, v, exp);
    endtask

    task automatic check_outs_a(input string name, input logic [3:0] m, input logic mi,
                                input logic [31:0] o, input logic [15:0] p, input logic [15:0] c);
        check({name, "_map"}, map_a, m);
        check({name, "_mir"}, mir_a, mi);
        check({name, "_ofs"}, ofs_a, o);
        check({name, "_prg"}, prg_a, p);
        check({name, "_chr"}, chr_a, c);
    endtask

    initial begin
        vecs[0] = '{mk(8'h13,8'h00,8'h02,8'h00,8'h00,8'h80,8'h00,8'h20,8'h00,8'h4C),
                    1'b0, 4'd0, 1'b0, 32'h0, 16'd64, 16'd16, 8'h40, 1'b1};
        vecs[1] = '{mk(8'h13,8'h00,8'h02,8'h00,8'h00,8'h80,8'h00,8'h20,8'h00,8'h4B),
                    1'b1, 4'd3, 1'b1, 32'h200, 16'h80, 16'h20, 8'h00, 1'b0};
        vecs[2] = '{mk(8'hE5,8'h78,8'h56,8'h34,8'h12,8'h01,8'h00,8'hFF,8'hFF,8'h08),
                    1'b1, 4'd5, 1'b0, 32'h12345678, 16'h0001, 16'hFFFF, 8'h00, 1'b0};
        vecs[3] = '{mk(8'h0F,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00),
                    1'b0, 4'd5, 1'b0, 32'h12345678, 16'h0001, 16'hFFFF, 8'h40, 1'b1};
        vecs[4] = '{mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00),
                    1'b1, 4'd0, 1'b0, 32'h0, 16'h0, 16'h0, 8'h00, 1'b0};

        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b1;
        tick();

        check("rst_ld", ld_a, 1'b0);
        check_outs_a("rst", 4'd0, 1'b0, 32'h0, 16'd64, 16'd16);
        check("rst_err", err_a, 1'b0);
        check("idle_oe", oe_a, 1'b0);
        check("idle_dout", dout_a, 8'h00);
        check("rst_prg_b", prg_b, 16'd64);
        check_status("rst_status", 1'b0, 8'h00);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 10; i++) bus_write(1'b0, DATA, vecs[v].bytes[8*i +: 8], 1'b0);
            check($sformatf("v%0d_ld_e0", v), ld_a, 1'b0);
            tick();
            check($sformatf("v%0d_ld_e1", v), ld_a, 1'b0);
            tick();
            check($sformatf("v%0d_ld_e2", v), ld_a, vecs[v].commit);
            check_outs_a($sformatf("v%0d", v), vecs[v].mapper, vecs[v].mirror,
                         vecs[v].ofs, vecs[v].prg, vecs[v].chr);
            tick();
            check($sformatf("v%0d_ld_e3", v), ld_a, 1'b0);
            check($sformatf("v%0d_err", v), err_a, vecs[v].status[6] | vecs[v].status[5]);
            check_status($sformatf("v%0d_status", v), 1'b0, vecs[v].status);
            if (vecs[v].clr) begin
                bus_write(1'b0, CTRL, 8'h02, 1'b0);
                check_status($sformatf("v%0d_clr", v), 1'b0, 8'h00);
            end
        end

        // Watchdog: 4 bytes then silence; expiry needs the counter to reach 15.
        for (int i = 0; i < 4; i++) bus_write(1'b0, DATA, vecs[2].bytes[8*i +: 8], 1'b0);
        check_status("wd_busy", 1'b0, 8'h84);
        repeat (14) idle_pulse();
        tick();
        check_status("wd_14", 1'b0, 8'h84);
        idle_pulse();
        tick();
        tick();
        check_status("wd_15", 1'b0, 8'h20);
        check("wd_err", err_a, 1'b1);
        check_outs_a("wd", 4'd0, 1'b0, 32'h0, 16'h0, 16'h0);
        for (int i = 0; i < 10; i++) bus_write(1'b0, DATA, vecs[1].bytes[8*i +: 8], 1'b0);
        tick();
        tick();
        check("wd_new_ld", ld_a, 1'b1);
        check_outs_a("wd_new", 4'd3, 1'b1, 32'h200, 16'h80, 16'h20);
        check_status("wd_keep", 1'b0, 8'h20);
        bus_write(1'b0, CTRL, 8'h02, 1'b0);
        check_status("wd_clr", 1'b0, 8'h00);

        // Abort mid-stream, then a full stream must start from the header.
        for (int i = 0; i < 5; i++) bus_write(1'b0, DATA, vecs[2].bytes[8*i +: 8], 1'b0);
        check_status("ab_busy", 1'b0, 8'h85);
        bus_write(1'b0, CTRL, 8'h01, 1'b0);
        check_status("ab_idle", 1'b0, 8'h00);
        check_outs_a("ab_keep", 4'd3, 1'b1, 32'h200, 16'h80, 16'h20);
        for (int i = 0; i < 10; i++) bus_write(1'b0, DATA, vecs[2].bytes[8*i +: 8], 1'b0);
        tick();
        tick();
        check("ab_new_ld", ld_a, 1'b1);
        check_outs_a("ab_new", 4'd5, 1'b0, 32'h12345678, 16'h0001, 16'hFFFF);

        // Reload collides with the final data write.
        for (int i = 0; i < 9; i++) bus_write(1'b0, DATA, vecs[1].bytes[8*i +: 8], 1'b0);
        bus_write(1'b0, DATA, vecs[1].bytes[79:72], 1'b1);
        check("rl_ld1", ld_a, 1'b1);
        check_outs_a("rl", 4'd0, 1'b0, 32'h0, 16'd64, 16'd16);
        tick();
        check("rl_ld2", ld_a, 1'b0);
        tick();
        check("rl_ld3", ld_a, 1'b0);
        check_outs_a("rl_hold", 4'd0, 1'b0, 32'h0, 16'd64, 16'd16);
        check_status("rl_status", 1'b0, 8'h00);

        // No-checksum instance: 9 bytes commit, a 10th opens a new stream.
        for (int i = 0; i < 9; i++) bus_write(1'b1, DATA, vecs[1].bytes[8*i +: 8], 1'b0);
        check("b_ld_e0", ld_b, 1'b0);
        tick();
        check("b_ld_e1", ld_b, 1'b0);
        tick();
        check("b_ld_e2", ld_b, 1'b1);
        check("b_map", map_b, 4'd3);
        check("b_mir", mir_b, 1'b1);
        check("b_ofs", ofs_b, 32'h200);
        check("b_prg", prg_b, 16'h80);
        check("b_chr", chr_b, 16'h20);
        tick();
        check("b_ld_e3", ld_b, 1'b0);
        bus_write(1'b1, DATA, 8'h4B, 1'b0);
        check_status("b_new", 1'b1, 8'h81);
        check("b_err", err_b, 1'b0);

        // Reset mid-stream drops the partial stream.
        for (int i = 0; i < 3; i++) bus_write(1'b0, DATA, vecs[2].bytes[8*i +: 8], 1'b0);
        @(negedge sysclk);
        reset = 1'b0;
        #2;
        check_outs_a("mrst", 4'd0, 1'b0, 32'h0, 16'd64, 16'd16);
        @(negedge sysclk);
        reset = 1'b1;
        tick();
        check_status("mrst_status", 1'b0, 8'h00);
        check("mrst_ld", ld_a, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
